design02_scheduler: RTL

Round-robin scheduler sharing one `mkDesign_02` datapath between two requesters. It arbitrates a request, then sequences the datapath's three methods in order: `start(a,b)`, then `result(c)`, then `check(d)`. It returns the captured `result` and `check` values to the winning requester. It sits between the requesters and the datapath and is the only driver of the datapath's enable and argument ports.

---
 rtl/design02_scheduler.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/design02_scheduler.sv
// design02_scheduler
//
// Round-robin front end that shares one mkDesign_02 datapath between two
// requesters. One request is taken at a time. For that request the block
// calls the datapath's start(a,b), then result(c), then check(d). It then
// returns the captured result and check values to the requester that won.
//
// Ports
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready    request handshake, N = 0,1
//   reqN_a/b/c/d               operands for start a/b, result c, check d
//   rspN_valid / rspN_ready    response handshake
//   rspN_result/check/err      captured datapath values, watchdog abort flag
//   dut_*                      datapath method enables, arguments and readies
//   dbg_state                  current FSM state, for observation only
//
// Handshake semantics (every valid/ready pair): a transfer happens on the
// rising edge where both valid and ready are 1. A valid that has been raised
// stays high, with its payload stable, until that transfer happens.
//
// Optional feature: define SCHED_TIMEOUT_EN to build in a watchdog. The
// watchdog aborts an operation that spends TIMEOUT cycles in START/WAIT_RES.
// The aborted operation is answered with err=1 and zero data.
module design02_scheduler #(
  parameter int W       = 6,
  parameter int TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_c,
  input  logic [W-1:0] req0_d,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_c,
  input  logic [W-1:0] req1_d,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_result,
  output logic [W-1:0] rsp0_check,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_result,
  output logic [W-1:0] rsp1_check,
  output logic         rsp1_err,
  output logic [W-1:0] dut_start_a,
  output logic [W-1:0] dut_start_b,
  output logic         dut_EN_start,
  input  logic         dut_STready,
  output logic [W-1:0] dut_result_c,
  input  logic [W-1:0] dut_result,
  input  logic         dut_RESready,
  output logic [W-1:0] dut_check_d,
  output logic         dut_EN_check,
  input  logic [W-1:0] dut_check,
  input  logic         dut_CHready,
  output logic [2:0]   dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_RES = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]   state_q, state_d;
  logic         last_q, last_d;     // index served most recently
  logic         gnt_q, gnt_d;       // index being served now
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [W-1:0] res_q, res_d, chk_q, chk_d;
  logic         err_q, err_d;

  logic sel;      // requester that would win this cycle
  logic accept;   // request handshake this cycle
  logic rsp_hs;   // response handshake this cycle
  logic abort;    // watchdog expiry with the current stage still stalled

  // When both requesters are valid, the one not served last wins. When only
  // one is valid, it wins. last_q resets to 1, so req0 wins the first tie.
  always_comb begin
    if (req0_valid && req1_valid) sel = ~last_q;
    else                          sel = req1_valid;
  end

  assign req0_ready = (state_q == S_IDLE) && req0_valid && !sel;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;

  assign dut_EN_start = (state_q == S_START) && dut_STready;
  assign dut_EN_check = (state_q == S_CHECK) && dut_CHready;

  assign rsp0_valid = (state_q == S_RESP) && !gnt_q;
  assign rsp1_valid = (state_q == S_RESP) && gnt_q;
  assign rsp_hs     = gnt_q ? rsp1_valid && rsp1_ready : rsp0_valid && rsp0_ready;

  // Both responders see the same captured registers; only valid is steered.
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_check  = chk_q;
  assign rsp1_check  = chk_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  // Datapath arguments come straight from the latched request. They stay
  // stable until the next accept.
  assign dut_start_a  = a_q;
  assign dut_start_b  = b_q;
  assign dut_result_c = c_q;
  assign dut_check_d  = d_q;

  assign dbg_state = state_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_wd;

  assign in_wd = (state_q == S_START) || (state_q == S_WAIT_RES);

  // Counts cycles spent in START and WAIT_RES. Accept clears it, which is
  // the same as clearing it on entry to START. It sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)                               cnt_d = '0;
    else if (in_wd && (cnt_q != {CW{1'b1}}))  cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of cycles already spent. The abort therefore
  // lands on the TIMEOUT-th cycle in START/WAIT_RES.
  assign abort = in_wd && (cnt_q == CW'(TIMEOUT - 1));
`else
  // Watchdog compiled out. The comparison is constant false; it only keeps
  // TIMEOUT referenced so both builds share one parameter list.
  assign abort = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    res_d   = res_q;
    chk_d   = chk_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          gnt_d   = sel;
          a_d     = sel ? req1_a : req0_a;
          b_d     = sel ? req1_b : req0_b;
          c_d     = sel ? req1_c : req0_c;
          d_d     = sel ? req1_d : req0_d;
          err_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (dut_STready) begin
          state_d = S_WAIT_RES;
        end else if (abort) begin
          res_d   = '0;
          chk_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT_RES: begin
        if (dut_RESready) begin
          res_d   = dut_result;
          state_d = S_CHECK;
        end else if (abort) begin
          res_d   = '0;
          chk_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_CHECK: begin
        // Capture the check value in the same cycle the enable fires.
        if (dut_CHready) begin
          chk_d   = dut_check;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      chk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      res_q   <= res_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end

endmodule
